// File: rtl/video_timing_pkg.sv
// video_timing_pkg: SVGA 800x600@60 raster constants and the
// side-band bundle carried alongside each pixel slot.
package video_timing_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  localparam int SVGA_H_TOTAL =
    SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL =
    SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  function automatic int cnt_width(input int total);
    return $clog2(total);
  endfunction

  localparam int SVGA_XW = cnt_width(SVGA_H_TOTAL);
  localparam int SVGA_YW = cnt_width(SVGA_V_TOTAL);

  typedef struct packed {
    logic req;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } tstage_t;

  localparam tstage_t STAGE_IDLE = '0;

endpackage

// File: rtl/timing_delay_line.sv
// timing_delay_line: enable-gated shift register of side-band
// stages; DEPTH=0 collapses to a wire.
module timing_delay_line
  import video_timing_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  tstage_t din,
  output tstage_t dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_sr
    tstage_t sr [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= STAGE_IDLE;
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, coordinate lookahead and
// delayed de/hsync/vsync for the display PHY.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = SVGA_H_ACTIVE,
  parameter int H_FP      = SVGA_H_FP,
  parameter int H_SYNC    = SVGA_H_SYNC,
  parameter int H_BP      = SVGA_H_BP,
  parameter int V_ACTIVE  = SVGA_V_ACTIVE,
  parameter int V_FP      = SVGA_V_FP,
  parameter int V_SYNC    = SVGA_V_SYNC,
  parameter int V_BP      = SVGA_V_BP,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOOKAHEAD = 4,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = cnt_width(H_TOTAL),
  localparam int YW       = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          req,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          line_start
);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_C = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT_C = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  logic    h_act;
  logic    v_act;
  logic    hs_raw;
  logic    vs_raw;
  tstage_t nxt;

  // v_cnt only moves at the h wrap, so vs_raw follows line boundaries
  assign h_act  = h_cnt < H_ACT_C;
  assign v_act  = v_cnt < V_ACT_C;
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  always_comb begin
    nxt     = STAGE_IDLE;
    nxt.req = h_act && v_act;
    nxt.hs  = hs_raw;
    nxt.vs  = vs_raw;
    nxt.ls  = h_act && v_act && (h_cnt == '0);
    nxt.fs  = nxt.ls && (v_cnt == '0);
  end

  tstage_t       st0;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st0 <= STAGE_IDLE;
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      st0 <= nxt;
      x_q <= h_cnt;
      y_q <= v_cnt;
    end
  end

  tstage_t dly;

  timing_delay_line #(
    .DEPTH(LOOKAHEAD)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (st0),
    .dout (dly)
  );

  assign req         = st0.req;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = dly.req;
  assign hsync       = ~(dly.hs ^ HS_POL);
  assign vsync       = ~(dly.vs ^ VS_POL);
  assign frame_start = dly.fs;
  assign line_start  = dly.ls;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: SVGA instance plus two small-raster
// instances (LOOKAHEAD 0 and 15) against an arithmetic model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint k     = 0;

  // default SVGA, LOOKAHEAD=4
  logic               d_req, d_de, d_hs, d_vs, d_fs, d_ls;
  logic [SVGA_XW-1:0] d_x;
  logic [SVGA_YW-1:0] d_y;
  // small raster 28x11, LOOKAHEAD=0
  logic       a_req, a_de, a_hs, a_vs, a_fs, a_ls;
  logic [4:0] a_x;
  logic [3:0] a_y;
  // small raster 28x11, LOOKAHEAD=15, negative sync polarity
  logic       b_req, b_de, b_hs, b_vs, b_fs, b_ls;
  logic [4:0] b_x;
  logic [3:0] b_y;

  video_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en), .req(d_req), .x(d_x), .y(d_y),
    .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .frame_start(d_fs), .line_start(d_ls));

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(0)
  ) u_la0 (
    .clk(clk), .rst(rst), .en(en), .req(a_req), .x(a_x), .y(a_y),
    .de(a_de), .hsync(a_hs), .vsync(a_vs),
    .frame_start(a_fs), .line_start(a_ls));

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(15)
  ) u_la15 (
    .clk(clk), .rst(rst), .en(en), .req(b_req), .x(b_x), .y(b_y),
    .de(b_de), .hsync(b_hs), .vsync(b_vs),
    .frame_start(b_fs), .line_start(b_ls));

  typedef struct packed {
    logic        req;
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
  } obs_t;

  // k = enabled edges since the last reset edge; every output is a
  // pure function of k and the raster geometry.
  function automatic obs_t model(input longint kk,
      input int ha, hf, hw, hb, va, vf, vw, vb, la,
      input bit hp, vp);
    longint ht, vt, c, h, v;
    obs_t o;
    bit act;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    if (kk >= 1) begin
      c = kk - 1;
      h = c % ht;
      v = (c / ht) % vt;
      o.x = 16'(h);
      o.y = 16'(v);
      o.req = (h < ha) && (v < va);
    end
    if (kk >= la + 1) begin
      c = kk - 1 - la;
      h = c % ht;
      v = (c / ht) % vt;
      act = (h < ha) && (v < va);
      o.de = act;
      o.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
      o.vs = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
      o.fs = act && h == 0 && v == 0;
      o.ls = act && h == 0;
    end
    return o;
  endfunction

  function automatic obs_t mk(input logic rq, input int xx, yy,
      input logic dd, hh, vv, ff, ll);
    obs_t o;
    o.req = rq; o.x = 16'(xx); o.y = 16'(yy);
    o.de = dd; o.hs = hh; o.vs = vv; o.fs = ff; o.ls = ll;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got req=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b want req=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b",
        nm, k, act.req, act.x, act.y, act.de, act.hs, act.vs, act.fs,
        act.ls, exp.req, exp.x, exp.y, exp.de, exp.hs, exp.vs,
        exp.fs, exp.ls);
    end
  endtask

  task automatic cmpi(input string nm, input longint act, exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s k=%0d got %0d want %0d", nm, k, act, exp);
    end
  endtask

  function automatic obs_t obs_d();
    return mk(d_req, int'(d_x), int'(d_y), d_de, d_hs, d_vs, d_fs, d_ls);
  endfunction

  always @(posedge clk) begin
    if (rst) k = 0;
    else if (en) k = k + 1;
  end

  always @(negedge clk) begin
    cmp("model_svga", obs_d(),
      model(k, 800, 40, 128, 88, 600, 1, 4, 23, 4, 1'b1, 1'b1));
    cmp("model_la0",
      mk(a_req, int'(a_x), int'(a_y), a_de, a_hs, a_vs, a_fs, a_ls),
      model(k, 16, 3, 5, 4, 6, 1, 2, 2, 0, 1'b1, 1'b1));
    cmp("model_la15",
      mk(b_req, int'(b_x), int'(b_y), b_de, b_hs, b_vs, b_fs, b_ls),
      model(k, 16, 3, 5, 4, 6, 1, 2, 2, 15, 1'b0, 1'b0));
  end

  typedef struct {
    int   kk;
    obs_t exp;
  } vec_t;

  vec_t tab[15];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(input longint target);
    int guard = 0;
    while (k < target && guard < 40000) begin
      tick();
      guard++;
    end
    cmpi("run_to_reached", k, target);
  endtask

  task automatic run_table();
    for (int i = 0; i < 15; i++) begin
      run_to(tab[i].kk);
      cmp($sformatf("vec%0d", i), obs_d(), tab[i].exp);
    end
  endtask

  initial begin
    obs_t snap;
    int cnt;
    bit frozen;
    int guard;
    //                 req  x    y  de hs vs fs ls
    tab[0]  = '{0,    mk(0, 0,   0, 0, 0, 0, 0, 0)};
    tab[1]  = '{1,    mk(1, 0,   0, 0, 0, 0, 0, 0)};
    tab[2]  = '{4,    mk(1, 3,   0, 0, 0, 0, 0, 0)};
    tab[3]  = '{5,    mk(1, 4,   0, 1, 0, 0, 1, 1)};
    tab[4]  = '{6,    mk(1, 5,   0, 1, 0, 0, 0, 0)};
    tab[5]  = '{800,  mk(1, 799, 0, 1, 0, 0, 0, 0)};
    tab[6]  = '{801,  mk(0, 800, 0, 1, 0, 0, 0, 0)};
    tab[7]  = '{804,  mk(0, 803, 0, 1, 0, 0, 0, 0)};
    tab[8]  = '{805,  mk(0, 804, 0, 0, 0, 0, 0, 0)};
    tab[9]  = '{844,  mk(0, 843, 0, 0, 0, 0, 0, 0)};
    tab[10] = '{845,  mk(0, 844, 0, 0, 1, 0, 0, 0)};
    tab[11] = '{972,  mk(0, 971, 0, 0, 1, 0, 0, 0)};
    tab[12] = '{973,  mk(0, 972, 0, 0, 0, 0, 0, 0)};
    tab[13] = '{1057, mk(1, 0,   1, 0, 0, 0, 0, 0)};
    tab[14] = '{1061, mk(1, 4,   1, 1, 0, 0, 0, 1)};

    // startup: 5 cycles of reset with en high
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    run_table();

    // clock-enable freeze at x=399, y=10 inside one measured line
    run_to(10 * 1056 + 5);
    cmpi("ls_line10", d_ls, 1);
    cnt = 0;
    frozen = 0;
    guard = 0;
    while (guard < 3000) begin
      guard++;
      if (!frozen && d_x == 399 && d_y == 10) begin
        snap = obs_d();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
          tick();
          cmp("frozen", obs_d(), snap);
        end
        en = 1'b1;
        tick();
        cnt++;
        cmpi("resume_x", d_x, 400);
        frozen = 1;
      end else begin
        tick();
        cnt++;
      end
      if (d_ls) break;
    end
    cmpi("freeze_seen", frozen, 1);
    cmpi("line_len_en", cnt, 1056);

    // mid-frame reset with de high
    run_to(20 * 1056 + 501);
    cmpi("pre_rst_x", d_x, 500);
    cmpi("pre_rst_de", d_de, 1);
    rst = 1'b1;
    tick();
    cmp("mid_rst", obs_d(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    run_table();

    // randomized en / occasional reset
    for (int i = 0; i < 6000; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end

    // small raster: frame period and vsync width
    rst = 1'b1;
    en  = 1'b1;
    tick();
    rst = 1'b0;
    guard = 0;
    while (!b_fs && guard < 1000) begin tick(); guard++; end
    cmpi("fs_found", b_fs, 1);
    cnt = 0;
    do begin tick(); cnt++; end while (!b_fs && cnt < 1000);
    cmpi("frame_period", cnt, 308);
    guard = 0;
    while (!a_vs && guard < 1000) begin tick(); guard++; end
    cmpi("vs_found", a_vs, 1);
    cmpi("vs_start_ls_y", a_y, 7);
    cnt = 0;
    while (a_vs && cnt < 1000) begin tick(); cnt++; end
    cmpi("vsync_len", cnt, 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator clocked from the rPLL divided output (clkoutd, 39.75 MHz ≈ SVGA 800x600@60 pixel clock).
- Produces hsync/vsync/data-enable for the display PHY.
- Also produces pixel coordinates a configurable number of cycles ahead of data-enable. This gives the downstream character/glyph renderer a fixed pipeline budget to fetch text RAM and font ROM.
- Single clock domain, no CDC.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- LOOKAHEAD, 4, cycles by which x/y/req lead de/hsync/vsync; legal range 0..15
- Derived constants, not overridable:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628)
  - XW = $clog2(H_TOTAL) (11)
  - YW = $clog2(V_TOTAL) (10)

Ports:
- clk  input  1  pixel clock (rPLL clkoutd)
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; when low, all state holds
- req  output  1  pixel request: (x,y) is inside the active area
- x  output  XW  horizontal coordinate of requested pixel
- y  output  YW  vertical coordinate of requested pixel
- de  output  1  data enable, req delayed by LOOKAHEAD
- hsync  output  1  horizontal sync at HS_POL level, aligned with de
- vsync  output  1  vertical sync at VS_POL level, aligned with de
- frame_start  output  1  one-cycle pulse coincident with de for pixel (0,0)
- line_start  output  1  one-cycle pulse coincident with de for x=0 of every active line

Behaviour:
- Counters: h_cnt counts 0..H_TOTAL-1 and wraps to 0. At the wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0. Both advance only when en=1.
- Reset (rst=1 at a clock edge):
  - h_cnt=0, v_cnt=0.
  - req=0, x=0, y=0, de=0, frame_start=0, line_start=0.
  - hsync=!HS_POL, vsync=!VS_POL.
  - All delay-line stages cleared to the same inactive values.
  - rst has priority over en. Mid-frame reset returns to this state on the next edge, with no partial-line artefacts afterward.
- Stage 0 (registered, 1-cycle latency from counters):
  - req = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - x = h_cnt, y = v_cnt. x/y are driven in blanking too; consumers qualify with req.
- Raw sync terms:
  - hs_raw = 1 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (840..967).
  - vs_raw = 1 for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (601..604).
  - vs_raw changes state only at h_cnt=0.
- Delay line:
  - {req, hs_raw, vs_raw, frame_pulse, line_pulse} pass through a LOOKAHEAD-deep shift register, advancing only when en=1.
  - Outputs: de = delayed req; hsync = delayed hs_raw XNOR HS_POL; vsync likewise with VS_POL.
  - frame_pulse = req && x==0 && y==0; line_pulse = req && x==0.
  - LOOKAHEAD=0: delay line is absent and de == req in the same cycle.
- Timing after reset release (en held 1): req first asserts at the edge 1 after release; de first asserts at edge 1+LOOKAHEAD.
- Periods: line = H_TOTAL cycles; frame = H_TOTAL*V_TOTAL cycles (663168 at defaults).
- en=0: counters, stage-0 registers and the delay line all hold. Outputs stay frozen, including any pulse, for the duration. When en returns high, the sequence resumes with no skipped or duplicated pixel.
- Arithmetic: all comparisons are unsigned against width-matched constants. No counter may overflow past TOTAL-1.

Decomposition:
- Package video_timing_pkg holds:
  - SVGA default constants (H_*/V_*).
  - Derived totals and widths.
  - A struct for one delay-line stage {req, hs, vs, fs, ls}.
- One natural sub-module: timing_delay_line. It is a parameterised-depth, enable-gated shift register of that struct with synchronous clear, reused later for aligning renderer side-band signals.

Test Plan:
- Reset/startup: hold rst 5 cycles, release with en=1 -> during reset all outputs inactive (hsync=vsync=0 with POL=1). req=1, x=0, y=0 at edge 1. de=1 and frame_start=1 at edge 5 (LOOKAHEAD=4).
- Horizontal timing: observe one line -> de high 800 cycles; hsync rises 840 cycles after de rise and stays high 128 cycles; next line_start 1056 cycles after the previous one.
- Vertical timing/wrap: run a full frame -> vsync high for exactly 4*1056=4224 cycles, beginning at the line-start of line 601. frame_start repeats every 663168 cycles. y wraps 627 -> 0 and x wraps 1055 -> 0 in the same cycle.
- Lookahead alignment: sample x on every req edge -> de asserts exactly LOOKAHEAD cycles later. Repeat with LOOKAHEAD=0 (de==req) and LOOKAHEAD=15.
- Clock enable: drop en for 7 cycles at x=399, y=10 -> all outputs frozen for those 7 cycles. x=400 follows at the first enabled edge; line length measured in enabled cycles is still 1056.
- Mid-frame reset: assert rst one cycle at x=500, y=300 with de=1 -> de=0, hsync/vsync inactive and x=y=0 on the next edge. The restart sequence is identical to the startup test.
